// File: rtl/ad_phase_buffer.sv
// PCI target address/data buffer: address-phase decode, burst address counter,
// write FIFO toward memory, registered read return. Define AD_IO_CMD_EN to also claim I/O cycles.
//
// state    | meaning
// IDLE     | waiting for an address phase that hits the window
// WRITE    | accepting write data phases into the FIFO
// RTA      | read turnaround; waits for FIFO drain, then issues first MEM_RD
// RDATA    | read data presented on AD_OUT with TRDY_N low
// RFETCH   | fetching the next burst word, AD_OUT held
module ad_phase_buffer #(
  parameter int                  AD_WIDTH  = 32,
  parameter int                  DEPTH     = 4,
  parameter int                  ADDR_STEP = 4,
  parameter logic [AD_WIDTH-1:0] BASE_ADDR = 32'h0000_1000,
  parameter logic [AD_WIDTH-1:0] ADDR_MASK = 32'hFFFF_F000
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                FRAME_N,
  input  logic                IRDY_N,
  input  logic [3:0]          CBE_N,
  input  logic [AD_WIDTH-1:0] AD_IN,
  output logic [AD_WIDTH-1:0] AD_OUT,
  output logic                AD_OE,
  output logic                DEVSEL_N,
  output logic                TRDY_N,
  output logic [AD_WIDTH-1:0] MEM_ADDR,
  output logic [AD_WIDTH-1:0] MEM_WDATA,
  output logic [3:0]          MEM_BE,
  output logic                MEM_WE,
  input  logic                MEM_READY,
  output logic                MEM_RD,
  input  logic [AD_WIDTH-1:0] MEM_RDATA
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [AD_WIDTH-1:0] STEP = AD_WIDTH'(ADDR_STEP);
  localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(DEPTH);

  localparam logic [3:0] CMD_MEM_RD = 4'b0110;
  localparam logic [3:0] CMD_MEM_WR = 4'b0111;
`ifdef AD_IO_CMD_EN
  localparam logic [3:0] CMD_IO_RD  = 4'b0010;
  localparam logic [3:0] CMD_IO_WR  = 4'b0011;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RTA,
    S_RDATA,
    S_RFETCH
  } state_t;

  state_t              state_q, state_d;
  logic [AD_WIDTH-1:0] addr_q, addr_d;
  logic                io_q, io_d;
  logic [AD_WIDTH-1:0] rdata_q, rdata_d;
  logic                rd_pend_q, rd_pend_d;

  logic [AD_WIDTH-1:0] fifo_addr_q [DEPTH];
  logic [AD_WIDTH-1:0] fifo_addr_d [DEPTH];
  logic [AD_WIDTH-1:0] fifo_data_q [DEPTH];
  logic [AD_WIDTH-1:0] fifo_data_d [DEPTH];
  logic [3:0]          fifo_be_q   [DEPTH];
  logic [3:0]          fifo_be_d   [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic trdy_n;
  logic ad_oe;
  logic mem_rd;
  logic addr_hit;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign addr_hit   = ((AD_IN & ADDR_MASK) == BASE_ADDR);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    io_d    = io_q;
    trdy_n  = 1'b1;
    ad_oe   = 1'b0;
    mem_rd  = 1'b0;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!FRAME_N && addr_hit) begin
          case (CBE_N)
            CMD_MEM_WR: begin
              state_d = S_WRITE;
              addr_d  = AD_IN;
              io_d    = 1'b0;
            end
            CMD_MEM_RD: begin
              state_d = S_RTA;
              addr_d  = AD_IN;
              io_d    = 1'b0;
            end
`ifdef AD_IO_CMD_EN
            CMD_IO_WR: begin
              state_d = S_WRITE;
              addr_d  = AD_IN;
              io_d    = 1'b1;
            end
            CMD_IO_RD: begin
              state_d = S_RTA;
              addr_d  = AD_IN;
              io_d    = 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end
      S_WRITE: begin
        trdy_n = fifo_full;
        if (!IRDY_N && !fifo_full) begin
          push = 1'b1;
          if (!io_q) addr_d = addr_q + STEP;
          if (FRAME_N) state_d = S_IDLE;
        end
      end
      S_RTA: begin
        // Reads wait for queued writes so they observe post-write memory.
        if (fifo_empty) begin
          mem_rd  = 1'b1;
          state_d = S_RDATA;
        end
      end
      S_RDATA: begin
        ad_oe  = 1'b1;
        trdy_n = 1'b0;
        if (!IRDY_N) begin
          if (!io_q) addr_d = addr_q + STEP;
          state_d = FRAME_N ? S_IDLE : S_RFETCH;
        end
      end
      S_RFETCH: begin
        ad_oe   = 1'b1;
        mem_rd  = 1'b1;
        state_d = S_RDATA;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pop = !fifo_empty && MEM_READY;

  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    fifo_be_d   = fifo_be_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push) begin
      fifo_addr_d[wr_ptr_q] = addr_q;
      fifo_data_d[wr_ptr_q] = AD_IN;
      fifo_be_d[wr_ptr_q]   = ~CBE_N;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // First cycle after a fetch passes MEM_RDATA through; later cycles replay the capture.
  always_comb begin
    rd_pend_d = mem_rd;
    rdata_d   = rd_pend_q ? MEM_RDATA : rdata_q;
  end

  always_comb begin
    AD_OUT    = rdata_d;
    AD_OE     = ad_oe;
    DEVSEL_N  = (state_q == S_IDLE);
    TRDY_N    = trdy_n;
    MEM_RD    = mem_rd;
    MEM_WE    = !fifo_empty;
    MEM_ADDR  = '0;
    MEM_WDATA = '0;
    MEM_BE    = '0;
    if (!fifo_empty) begin
      MEM_ADDR  = fifo_addr_q[rd_ptr_q];
      MEM_WDATA = fifo_data_q[rd_ptr_q];
      MEM_BE    = fifo_be_q[rd_ptr_q];
    end else if (mem_rd) begin
      MEM_ADDR  = addr_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      io_q      <= 1'b0;
      rdata_q   <= '0;
      rd_pend_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
        fifo_be_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      io_q        <= io_d;
      rdata_q     <= rdata_d;
      rd_pend_q   <= rd_pend_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
      fifo_be_q   <= fifo_be_d;
    end
  end

endmodule

// File: doc/ad_phase_buffer.md
# ad_phase_buffer

Parametrised PCI target address/data buffer between the AD bus and the local memory port. It latches address and command in the address phase and decodes the target window. It runs an auto-incrementing burst address counter, queues write data phases in a FIFO toward memory and returns read data with an explicit turnaround and output enable instead of tri-state muxing.

## Interface
- AD_WIDTH, 32, width of AD bus, addresses and memory data
- DEPTH, 4, write FIFO entries (power of two, ≥2)
- ADDR_STEP, 4, burst address increment per completed data phase
- BASE_ADDR, 32'h0000_1000, target window base
- ADDR_MASK, 32'hFFFF_F000, bits compared against BASE_ADDR
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous active-low reset
- FRAME_N  in  1  PCI FRAME#
- IRDY_N  in  1  PCI IRDY#
- CBE_N  in  4  command (address phase) / byte enables, active low (data phase)
- AD_IN  in  AD_WIDTH  AD bus input
- AD_OUT  out  AD_WIDTH  read data toward AD bus
- AD_OE  out  1  AD output enable (external pad driver)
- DEVSEL_N  out  1  device select, low while claimed
- TRDY_N  out  1  target ready
- MEM_ADDR  out  AD_WIDTH  memory address
- MEM_WDATA  out  AD_WIDTH  memory write data
- MEM_BE  out  4  memory byte enables, active high
- MEM_WE  out  1  memory write strobe
- MEM_READY  in  1  memory accepts write this cycle
- MEM_RD  out  1  memory read strobe; MEM_RDATA valid next cycle
- MEM_RDATA  in  AD_WIDTH  memory read data

## Operation
- States: IDLE, WRITE, RTA, RDATA, RFETCH.
- IDLE: on edge with FRAME_N=0 and (AD_IN & ADDR_MASK)==BASE_ADDR, latch AD_IN into addr counter and decode CBE_N.
  - 4'b0111 (mem write) -> WRITE.
  - 4'b0110 (mem read) -> RTA.
  - Any other command, or no address match: stay IDLE, no DEVSEL_N, no TRDY_N.
- Data phase completes on an edge with IRDY_N=0 and TRDY_N=0; counter += ADDR_STEP, wrapping modulo 2^AD_WIDTH.
- WRITE: TRDY_N=0 iff FIFO not full (combinational). On completion push {counter, AD_IN, ~CBE_N}. Completion with FRAME_N=1 -> IDLE.
- FIFO drain runs independently of the bus FSM.
  - FIFO non-empty: MEM_WE=1 with head entry on MEM_ADDR/MEM_WDATA/MEM_BE; pop on edge with MEM_READY=1.
  - Push and pop on the same edge: count unchanged.
- RTA: AD_OE=0, TRDY_N=1. When FIFO empty (write-before-read ordering), MEM_RD=1, MEM_ADDR=counter, go RDATA; otherwise hold.
- RDATA: AD_OE=1, AD_OUT=registered MEM_RDATA, TRDY_N=0.
  - Completion with FRAME_N=1 -> IDLE.
  - Completion with FRAME_N=0 -> RFETCH.
- RFETCH: MEM_RD=1 at the new counter, AD_OE=1, AD_OUT held, TRDY_N=1 -> RDATA.
- DEVSEL_N=0 in every state except IDLE.

## Timing
- Reset values: AD_OUT=0, AD_OE=0, DEVSEL_N=1, TRDY_N=1, MEM_ADDR=0, MEM_WDATA=0, MEM_BE=0, MEM_WE=0, MEM_RD=0, FIFO empty, state IDLE.
- Assertion of RST_N mid-transaction flushes the FIFO immediately; queued writes are lost.
- Write latency: DEVSEL_N/TRDY_N low the cycle after the address edge; one data phase per cycle while not full. An entry reaches MEM_WE the cycle after push.
- Read latency, address edge to first TRDY_N=0 with FIFO empty: 2 cycles (RTA, RDATA). Subsequent reads take one data phase per 2 cycles.
- MEM_RD and MEM_WE are never high in the same cycle.

## Configuration
- AD_IO_CMD_EN defined: also claims I/O read (4'b0010 -> RTA) and I/O write (4'b0011 -> WRITE). I/O bursts are not incremented; counter holds.
- AD_IO_CMD_EN undefined: I/O commands are ignored like any unsupported command.

## Test plan
- Write burst of 3 at 32'h0000_1000, IRDY_N=0, MEM_READY=1 -> MEM_WE pushes addresses 1000/1004/1008 with matching data; DEVSEL_N back to 1 after last phase.
- Write burst of 6 with MEM_READY=0 -> TRDY_N=0 for 4 phases, then 1 while full. Release MEM_READY -> remaining 2 phases complete, all 6 drained in order.
- Read of 2 after a queued write to 32'h1000 -> MEM_RD waits until MEM_WE drains. AD_OUT shows post-write data, AD_OE=0 in RTA, TRDY_N pattern 1,0,1,0.
- Address 32'h0000_2000 or command 4'b0001 -> DEVSEL_N, TRDY_N, AD_OE stay 1/1/0.
- RST_N=0 with 3 FIFO entries mid-WRITE -> all outputs at reset values next sample, no further MEM_WE.
- AD_IO_CMD_EN defined, I/O write burst of 2 at 32'h1000 -> both entries to address 1000. Undefined -> no claim.
